// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU: opcodes, bus-source and ALU encodings,
// sequencer states and opcode classification.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOVI = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] IE_ALU = 2'b00;
  localparam logic [1:0] IE_SW  = 2'b01;
  localparam logic [1:0] IE_IMM = 2'b10;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_ENTER,
    ST_EXEC_A,
    ST_EXEC_G,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_LOAD,
    CL_MOVI,
    CL_MOV,
    CL_ALU,
    CL_HALT,
    CL_NOP
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    case (op)
      OP_LOAD:                         return CL_LOAD;
      OP_MOVI:                         return CL_MOVI;
      OP_MOV:                          return CL_MOV;
      OP_ADD, OP_SUB, OP_AND, OP_NOT:  return CL_ALU;
      OP_HALT:                         return CL_HALT;
      default:                         return CL_NOP;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_NOT:  return ALU_NOT;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer: latches one instruction per handshake and steps it through
// fetch/decode/execute/writeback, driving datapath strobes Moore-style from state and IR.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            enter,
  output logic [1:0]      IE_EN,
  output logic [3:0]      inst_out,
  output logic [NREG-1:0] rf_we,
  output logic [1:0]      rf_rd_sel,
  output logic            a_we,
  output logic            g_we,
  output logic [2:0]      alu_op,
  output logic            done,
  output logic            halted
);

  state_e      state;
  state_e      state_nxt;
  logic [9:0]  ir;
  logic        halted_q;
  logic [3:0]  opcode;
  logic [1:0]  rx;
  logic [1:0]  ry;
  op_class_e   op_class;

  assign opcode   = ir[9:6];
  assign rx       = ir[5:4];
  assign ry       = ir[3:2];
  assign op_class = classify(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      ir       <= '0;
      halted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && instr_valid)
        ir <= instr;
      if (state == ST_DECODE && op_class == CL_HALT)
        halted_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:
        if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE:
        case (op_class)
          CL_LOAD: state_nxt = ST_WAIT_ENTER;
          CL_MOVI: state_nxt = ST_WB;
          CL_MOV:  state_nxt = ST_EXEC_G;
          CL_ALU:  state_nxt = ST_EXEC_A;
          CL_HALT: state_nxt = ST_HALT;
          default: state_nxt = ST_FETCH;
        endcase
      ST_WAIT_ENTER:
        if (enter) state_nxt = ST_WB;
      ST_EXEC_A: state_nxt = ST_EXEC_G;
      ST_EXEC_G: state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    IE_EN       = IE_ALU;
    rf_we       = '0;
    rf_rd_sel   = '0;
    a_we        = 1'b0;
    g_we        = 1'b0;
    alu_op      = ALU_PASS;
    done        = 1'b0;
    case (state)
      ST_FETCH: instr_ready = 1'b1;
      ST_DECODE:
        done = (op_class == CL_NOP) || (op_class == CL_HALT);
      ST_WAIT_ENTER: IE_EN = IE_SW;
      ST_EXEC_A: begin
        rf_rd_sel = rx;
        a_we      = 1'b1;
      end
      ST_EXEC_G: begin
        // NOT is unary: the operand already in A came from Rx, so read Rx again.
        rf_rd_sel = (opcode == OP_NOT) ? rx : ry;
        alu_op    = alu_op_of(opcode);
        g_we      = 1'b1;
      end
      ST_WB: begin
        rf_we = NREG'(1) << rx;
        done  = 1'b1;
        case (op_class)
          CL_MOVI: IE_EN = IE_IMM;
          CL_LOAD: IE_EN = IE_SW;
          default: IE_EN = IE_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign inst_out = ir[3:0];
  assign halted   = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle vector table plus hand-written
// sequences for LOAD/enter timing, HALT and asynchronous reset abort.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       enter;
  logic [1:0] IE_EN;
  logic [3:0] inst_out;
  logic [3:0] rf_we;
  logic [1:0] rf_rd_sel;
  logic       a_we;
  logic       g_we;
  logic [2:0] alu_op;
  logic       done;
  logic       halted;

  int unsigned errors = 0;
  int unsigned checks = 0;

  control_unit #(.NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .enter       (enter),
    .IE_EN       (IE_EN),
    .inst_out    (inst_out),
    .rf_we       (rf_we),
    .rf_rd_sel   (rf_rd_sel),
    .a_we        (a_we),
    .g_we        (g_we),
    .alu_op      (alu_op),
    .done        (done),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // {ready, IE_EN, rf_we, rd_sel, a_we, g_we, alu_op, done, halted}
  logic [15:0] obs;
  assign obs = {instr_ready, IE_EN, rf_we, rf_rd_sel, a_we, g_we, alu_op, done, halted};

  typedef struct {
    string       name;
    logic        v;
    logic [9:0]  in;
    logic        en;
    logic [15:0] exp;
    logic        ci;
    logic [3:0]  imm;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] e(logic rdy, logic [1:0] ie, logic [3:0] we, logic [1:0] rs,
                                    logic a, logic g, logic [2:0] op, logic dn, logic hl);
    return {rdy, ie, we, rs, a, g, op, dn, hl};
  endfunction

  function automatic vec_t mk(string nm, logic v, logic [9:0] in, logic en,
                              logic rdy, logic [1:0] ie, logic [3:0] we, logic [1:0] rs,
                              logic a, logic g, logic [2:0] op, logic dn,
                              logic ci, logic [3:0] imm);
    vec_t r;
    r.name = nm; r.v = v; r.in = in; r.en = en;
    r.exp  = e(rdy, ie, we, rs, a, g, op, dn, 1'b0);
    r.ci   = ci; r.imm = imm;
    return r;
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (rdy,ie,we,rs,a,g,op,dn,hl)", nm, act, exp);
    end
  endtask

  task automatic check_imm(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: inst_out got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] v_idle, v_reset, v_wait, v_halt;

  initial begin
    v_idle  = e(1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0);
    v_reset = v_idle;
    v_wait  = e(0, 2'b01, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0);
    v_halt  = e(0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 1);

    //             name         v  in      en rdy ie     we       rs    a  g  op      dn ci imm
    tbl.push_back(mk("idle",     0, 10'h000, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("idle_ent", 0, 10'h000, 1, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("movi_dec", 1, 10'h06A, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("movi_wb",  0, 10'h06A, 0, 0, 2'b10, 4'b0100, 2'b00, 0, 0, 3'b000, 1, 1, 4'hA));
    tbl.push_back(mk("movi_ret", 0, 10'h06A, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("add_dec",  1, 10'h0DC, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("add_ea",   0, 10'h0DC, 0, 0, 2'b00, 4'b0000, 2'b01, 1, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("add_eg",   0, 10'h0DC, 0, 0, 2'b00, 4'b0000, 2'b11, 0, 1, 3'b001, 0, 0, 4'h0));
    tbl.push_back(mk("add_wb",   0, 10'h0DC, 0, 0, 2'b00, 4'b0010, 2'b00, 0, 0, 3'b000, 1, 0, 4'h0));
    tbl.push_back(mk("add_ret",  0, 10'h0DC, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("sub_dec",  1, 10'h130, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("sub_ea",   0, 10'h130, 0, 0, 2'b00, 4'b0000, 2'b11, 1, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("sub_eg",   0, 10'h130, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 1, 3'b010, 0, 0, 4'h0));
    tbl.push_back(mk("sub_wb",   0, 10'h130, 0, 0, 2'b00, 4'b1000, 2'b00, 0, 0, 3'b000, 1, 0, 4'h0));
    tbl.push_back(mk("sub_ret",  0, 10'h130, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("mov_dec",  1, 10'h088, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("mov_eg",   0, 10'h088, 0, 0, 2'b00, 4'b0000, 2'b10, 0, 1, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("mov_wb",   0, 10'h088, 0, 0, 2'b00, 4'b0001, 2'b00, 0, 0, 3'b000, 1, 0, 4'h0));
    tbl.push_back(mk("mov_ret",  0, 10'h088, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("not_dec",  1, 10'h1A0, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("not_ea",   0, 10'h1A0, 0, 0, 2'b00, 4'b0000, 2'b10, 1, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("not_eg",   0, 10'h1A0, 0, 0, 2'b00, 4'b0000, 2'b10, 0, 1, 3'b100, 0, 0, 4'h0));
    tbl.push_back(mk("not_wb",   0, 10'h1A0, 0, 0, 2'b00, 4'b0100, 2'b00, 0, 0, 3'b000, 1, 0, 4'h0));
    tbl.push_back(mk("not_ret",  0, 10'h1A0, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("and_dec",  1, 10'h154, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("and_ea",   0, 10'h154, 0, 0, 2'b00, 4'b0000, 2'b01, 1, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("and_eg",   0, 10'h154, 0, 0, 2'b00, 4'b0000, 2'b01, 0, 1, 3'b011, 0, 0, 4'h0));
    tbl.push_back(mk("and_wb",   0, 10'h154, 0, 0, 2'b00, 4'b0010, 2'b00, 0, 0, 3'b000, 1, 0, 4'h0));
    tbl.push_back(mk("and_ret",  0, 10'h154, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("nop_dec",  1, 10'h280, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 1, 0, 4'h0));
    tbl.push_back(mk("nop_ret",  1, 10'h055, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("movi2_dec",1, 10'h055, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));
    tbl.push_back(mk("movi2_wb", 0, 10'h055, 0, 0, 2'b10, 4'b0010, 2'b00, 0, 0, 3'b000, 1, 1, 4'h5));
    tbl.push_back(mk("movi2_ret",0, 10'h055, 0, 1, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0, 4'h0));

    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; enter = 1'b0;
    #12;
    check("reset_state", obs, v_reset);
    check_imm("reset_imm", inst_out, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      instr_valid = tbl[i].v;
      instr       = tbl[i].in;
      enter       = tbl[i].en;
      step();
      check(tbl[i].name, obs, tbl[i].exp);
      if (tbl[i].ci) check_imm(tbl[i].name, inst_out, tbl[i].imm);
    end
    instr_valid = 1'b0; enter = 1'b0;

    // LOAD R0: enter during DECODE is lost, real enter arrives 20 cycles later
    instr = 10'h000; instr_valid = 1'b1;
    step();
    check("load_dec", obs, e(0, 2'b00, 4'b0000, 2'b00, 0, 0, 3'b000, 0, 0));
    instr_valid = 1'b0; enter = 1'b1;
    step();
    check("load_wait_entry", obs, v_wait);
    enter = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("load_wait_%0d", c), obs, v_wait);
    end
    enter = 1'b1;
    step();
    check("load_wb", obs, e(0, 2'b01, 4'b0001, 2'b00, 0, 0, 3'b000, 1, 0));
    enter = 1'b0;
    step();
    check("load_ret", obs, v_idle);

    // HALT then further instructions are ignored
    instr = 10'h3C0; instr_valid = 1'b1;
    step();
    check("halt_dec", {instr_ready, rf_we, done}, {1'b0, 4'b0000, 1'b1});
    instr = 10'h06A;
    for (int c = 0; c < 8; c++) begin
      enter = c[0];
      step();
      check($sformatf("halt_hold_%0d", c), obs, v_halt);
    end
    enter = 1'b0; instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_reset", obs, v_reset);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD aborted by reset during EXEC_G
    instr = 10'h0DC; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    check("abort_eg", obs, e(0, 2'b00, 4'b0000, 2'b11, 0, 1, 3'b001, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", obs, v_reset);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("abort_after_%0d", c), obs, v_idle);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 10-bit CPU. It accepts one instruction word per handshake, latches it in an instruction register, and steps through fetch/decode/execute/writeback. Each cycle it drives the bus-source select (IE_EN), the 4-bit immediate, register-file read/write strobes, and the ALU A/G register loads and ALU op. It sits directly upstream of the datapath source multiplexer and the register file, and is the only block that drives IE_EN.

## Interface
Parameters:
- NREG, 4: number of general registers; sets rf_we width; rf_rd_sel is log2(NREG) = 2 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  10  instruction word: [9:6] opcode, [5:4] Rx, [3:2] Ry, [3:0] imm.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  control unit can accept an instruction.
- enter  in  1  single-cycle, already-synchronized key pulse; confirms switch input.
- IE_EN  out  2  bus source: 00 ALU, 01 switches, 10 immediate.
- inst_out  out  4  immediate field from IR[3:0], zero-extended downstream.
- rf_we  out  NREG  one-hot register write strobe.
- rf_rd_sel  out  2  register read select feeding the ALU.
- a_we  out  1  load ALU operand register A.
- g_we  out  1  load ALU result register G.
- alu_op  out  3  000 PASS, 001 ADD, 010 SUB, 011 AND, 100 NOT.
- done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  sticky once HALT retires.

## Operation
- Opcodes: 0000 LOAD (Rx←sw, waits for enter); 0001 MOVI (Rx←imm); 0010 MOV (Rx←Ry via PASS); 0011 ADD, 0100 SUB, 0101 AND (Rx←Rx op Ry); 0110 NOT (Rx←~Rx); 1111 HALT; all others NOP.
- States: FETCH, DECODE, WAIT_ENTER, EXEC_A, EXEC_G, WB, HALT.
- FETCH: instr_ready=1. On instr_valid&&instr_ready, IR←instr and go to DECODE.
- DECODE:
  - LOAD → WAIT_ENTER.
  - MOVI → WB.
  - MOV → EXEC_G.
  - ADD/SUB/AND/NOT → EXEC_A.
  - HALT → HALT with done=1 and halted set.
  - NOP → FETCH with done=1.
- WAIT_ENTER: IE_EN=01. On enter, go to WB. enter is ignored in every other state.
- EXEC_A: rf_rd_sel=Rx, a_we=1.
- EXEC_G: rf_rd_sel=Ry (Rx for NOT), alu_op per opcode, g_we=1.
- WB: rf_we[Rx]=1, done=1, then FETCH.
  - IE_EN=10 for MOVI, 01 for LOAD, 00 otherwise.
- HALT is terminal until reset; instr_ready=0.
- Outside WB/WAIT_ENTER, IE_EN=00.
- At most one rf_we bit is high, and only in WB. a_we and g_we are never high in the same cycle.
- Default outputs in any state not listed above: 0.

## Timing
- Outputs are decoded from the state register and IR (Moore style); no combinational path from instr or enter to outputs.
- Cycles from handshake edge to the done cycle, inclusive:
  - MOVI: 2 (DECODE, WB).
  - MOV: 3.
  - ALU ops: 4 (DECODE, EXEC_A, EXEC_G, WB).
  - LOAD: 2 + wait for enter.
- Back-to-back: after the done cycle, FETCH accepts the next instruction in the following cycle. Peak rate is one MOVI per 3 cycles.
- enter arriving in the DECODE cycle of a LOAD is lost; a later pulse is required.
- Reset values: state=FETCH, IR=0, halted=0, instr_ready=1, all other outputs 0.
- Reset asserted mid-instruction aborts it immediately: strobes drop asynchronously and the register write does not occur.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants;
  - IE_EN encodings IE_ALU/IE_SW/IE_IMM (shared with the source multiplexer);
  - alu_op encodings (shared with the ALU);
  - the state enum.
- No sub-module. Opcode classification is a package function used by the DECODE transition logic.

## Test plan
- Reset mid-EXEC_G of ADD → all strobes 0 immediately; state=FETCH and instr_ready=1 after release; no rf_we pulse.
- MOVI R2,#0xA (instr=0001_10_1010) → DECODE, then WB with IE_EN=10, inst_out=1010, rf_we=0100, done=1; instr_ready=1 on the next cycle.
- ADD R1,R3 (0011_01_11_00) → EXEC_A: rf_rd_sel=01, a_we=1; EXEC_G: rf_rd_sel=11, alu_op=001, g_we=1; WB: IE_EN=00, rf_we=0010. Total 4 cycles.
- LOAD R0 with enter delayed 20 cycles → IE_EN=01 held throughout; rf_we=0001 exactly one cycle after the enter pulse. An enter in the DECODE cycle is ignored.
- HALT (1111_000000) → done pulse, halted=1, instr_ready=0 forever; instr_valid afterwards is ignored until rst_n.
- NOP (1010_000000) then immediate MOVI → NOP done after 1 cycle, no strobes; the MOVI is accepted on the next FETCH.
